// File: rtl/rio_frame_codec.sv
// Frame codec for the rio SPI link: unpacks rx buffers into channel commands,
// packs feedback into tx buffers, and owns the packet watchdog and E-stop state.
module rio_frame_codec #(
  parameter int          BUFFER_SIZE    = 240,
  parameter int          NUM_JOINTS     = 5,
  parameter int          NUM_VOUTS      = 1,
  parameter int          NUM_VINS       = 1,
  parameter int          NUM_DOUT_BYTES = 1,
  parameter int          NUM_DIN_BYTES  = 1,
  parameter logic [31:0] RX_MAGIC       = 32'h74697277,
  parameter logic [31:0] TX_DATA        = 32'h64617461,
  parameter logic [31:0] TX_ESTOP       = 32'h65737470,
  parameter int          TIMEOUT_CYCLES = 4800000
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   frame_done,
  input  logic [BUFFER_SIZE-1:0]                                 rx_data,
  output logic [BUFFER_SIZE-1:0]                                 tx_data,
  input  logic                                                   estop_in,
  input  logic [32*NUM_JOINTS-1:0]                               joint_feedback,
  input  logic [(NUM_VINS > 0 ? 32*NUM_VINS : 1)-1:0]            process_variable,
  input  logic [(NUM_DIN_BYTES > 0 ? 8*NUM_DIN_BYTES : 1)-1:0]   din,
  output logic [32*NUM_JOINTS-1:0]                               joint_freq_cmd,
  output logic [NUM_JOINTS-1:0]                                  joint_enable,
  output logic [(NUM_VOUTS > 0 ? 32*NUM_VOUTS : 1)-1:0]          setpoint,
  output logic [(NUM_DOUT_BYTES > 0 ? 8*NUM_DOUT_BYTES : 1)-1:0] dout,
  output logic                                                   error,
  output logic [15:0]                                            bad_frames
);

  localparam int JEN_BYTES = (NUM_JOINTS + 7) / 8;
  localparam int RX_BITS   = 32*(1+NUM_JOINTS+NUM_VOUTS) + 8*(JEN_BYTES+NUM_DOUT_BYTES);
  localparam int TX_BITS   = 32*(1+NUM_JOINTS+NUM_VINS) + 8*NUM_DIN_BYTES;
  localparam int EN_LO     = BUFFER_SIZE - 32*(1+NUM_JOINTS+NUM_VOUTS) - 8*JEN_BYTES;
  localparam int DOUT_LO   = BUFFER_SIZE - RX_BITS;
  localparam int DIN_LO    = BUFFER_SIZE - TX_BITS;
  localparam int SP_W      = NUM_VOUTS > 0 ? 32*NUM_VOUTS : 1;
  localparam int DOUT_W    = NUM_DOUT_BYTES > 0 ? 8*NUM_DOUT_BYTES : 1;
  localparam int WD_W      = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BUFFER_SIZE-1:0] TX_RESET =
    {TX_DATA[7:0], TX_DATA[15:8], TX_DATA[23:16], TX_DATA[31:24], {(BUFFER_SIZE-32){1'b0}}};

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_TIMEOUT, S_ESTOP} state_t;

  state_t                   state, state_next;
  logic [WD_W-1:0]          watchdog;
  logic [31:0]              header;
  logic                     header_ok, valid;
  logic [32*NUM_JOINTS-1:0] dec_cmd;
  logic [NUM_JOINTS-1:0]    dec_en;
  logic [SP_W-1:0]          dec_sp;
  logic [DOUT_W-1:0]        dec_dout;
  logic [BUFFER_SIZE-1:0]   tx_next;

  // Words travel least-significant byte first, so the field is byte-reversed.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb begin
    header   = swap_bytes(rx_data[BUFFER_SIZE-1 -: 32]);
    dec_cmd  = '0;
    dec_en   = '0;
    dec_sp   = '0;
    dec_dout = '0;
    for (int k = 0; k < NUM_JOINTS; k++)
      dec_cmd[32*k +: 32] = swap_bytes(rx_data[BUFFER_SIZE-32*(k+2) +: 32]);
    for (int v = 0; v < NUM_VOUTS; v++)
      dec_sp[32*v +: 32] = swap_bytes(rx_data[BUFFER_SIZE-32*(NUM_JOINTS+v+2) +: 32]);
    for (int j = 0; j < NUM_JOINTS; j++)
      dec_en[j] = rx_data[EN_LO+j];
    for (int b = 0; b < NUM_DOUT_BYTES; b++)
      dec_dout[8*b +: 8] = rx_data[DOUT_LO+8*b +: 8];
  end

  assign header_ok = (header == RX_MAGIC);
  assign valid     = frame_done && header_ok;
  assign error     = (state != S_RUN);

  always_comb begin
    state_next = state;
    if (estop_in) begin
      state_next = S_ESTOP;
    end else begin
      case (state)
        S_WAIT:    if (valid) state_next = S_RUN;
        S_RUN:     if (!valid && watchdog == WD_LAST) state_next = S_TIMEOUT;
        S_TIMEOUT: if (valid) state_next = S_RUN;
        S_ESTOP:   if (valid) state_next = S_WAIT;
        default:   state_next = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          watchdog <= '0;
    else if (state != S_RUN || valid)    watchdog <= '0;
    else if (watchdog != WD_LAST)        watchdog <= watchdog + 1'b1;
  end

  // Commands are forced to zero on the same edge the state leaves RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joint_freq_cmd <= '0;
      joint_enable   <= '0;
      setpoint       <= '0;
      dout           <= '0;
    end else if (state_next != S_RUN) begin
      joint_freq_cmd <= '0;
      joint_enable   <= '0;
      setpoint       <= '0;
      dout           <= '0;
    end else if (valid) begin
      joint_freq_cmd <= dec_cmd;
      joint_enable   <= dec_en;
      setpoint       <= dec_sp;
      dout           <= dec_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bad_frames <= '0;
    else if (frame_done && !header_ok && bad_frames != 16'hFFFF)
      bad_frames <= bad_frames + 16'd1;
  end

  always_comb begin
    tx_next = '0;
    tx_next[BUFFER_SIZE-1 -: 32] =
      swap_bytes((state == S_ESTOP || estop_in) ? TX_ESTOP : TX_DATA);
    for (int k = 0; k < NUM_JOINTS; k++)
      tx_next[BUFFER_SIZE-32*(k+2) +: 32] = swap_bytes(joint_feedback[32*k +: 32]);
    for (int v = 0; v < NUM_VINS; v++)
      tx_next[BUFFER_SIZE-32*(NUM_JOINTS+v+2) +: 32] = swap_bytes(process_variable[32*v +: 32]);
    for (int b = 0; b < NUM_DIN_BYTES; b++)
      tx_next[DIN_LO+8*b +: 8] = din[8*b +: 8];
  end

  // Snapshot on every frame, valid or not, so the buffer is stable for the next transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tx_data <= TX_RESET;
    else if (frame_done) tx_data <= tx_next;
  end

endmodule

// File: tb/tb_rio_frame_codec.sv
// Directed bench for rio_frame_codec: a default-width instance with a short
// watchdog, and a wide instance exercising multi-byte enable and din groups.
module tb_rio_frame_codec;

  localparam int BA = 240;
  localparam int BB = 400;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic          frame_done_a, estop_a, err_a;
  logic [BA-1:0] rx_a, tx_a;
  logic [159:0]  fb_a, cmd_a;
  logic [31:0]   pv_a, sp_a;
  logic [7:0]    din_a, dout_a;
  logic [4:0]    en_a;
  logic [15:0]   bad_a;

  logic          frame_done_b, estop_b, err_b;
  logic [BB-1:0] rx_b, tx_b;
  logic [287:0]  fb_b, cmd_b;
  logic [63:0]   pv_b;
  logic [15:0]   din_b, bad_b;
  logic [31:0]   sp_b;
  logic [7:0]    dout_b;
  logic [8:0]    en_b;

  rio_frame_codec #(.BUFFER_SIZE(BA), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_done(frame_done_a), .rx_data(rx_a),
    .tx_data(tx_a), .estop_in(estop_a), .joint_feedback(fb_a),
    .process_variable(pv_a), .din(din_a), .joint_freq_cmd(cmd_a),
    .joint_enable(en_a), .setpoint(sp_a), .dout(dout_a), .error(err_a),
    .bad_frames(bad_a)
  );

  rio_frame_codec #(.BUFFER_SIZE(BB), .NUM_JOINTS(9), .NUM_VINS(2),
                    .NUM_DIN_BYTES(2), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_done(frame_done_b), .rx_data(rx_b),
    .tx_data(tx_b), .estop_in(estop_b), .joint_feedback(fb_b),
    .process_variable(pv_b), .din(din_b), .joint_freq_cmd(cmd_b),
    .joint_enable(en_b), .setpoint(sp_b), .dout(dout_b), .error(err_b),
    .bad_frames(bad_b)
  );

  function automatic logic [31:0] sw32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Default-layout frame: header, cmd0, cmd1..3 zero, cmd4, setpoint, enable byte, dout byte.
  function automatic logic [BA-1:0] frame_a(input logic [31:0] hdr, input logic [31:0] c0,
                                            input logic [31:0] c4, input logic [31:0] sp,
                                            input logic [7:0] en, input logic [7:0] dv);
    return {sw32(hdr), sw32(c0), 96'h0, sw32(c4), sw32(sp), en, dv};
  endfunction

  task automatic send_a(input logic [BA-1:0] f);
    rx_a = f;
    frame_done_a = 1'b1;
    @(posedge clk); #1;
    frame_done_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    n_checks++;
    if (err_a !== 1'b1) $display("[TB] FAIL reset_error: got %b expected 1", err_a);
    else n_pass++;
    n_checks++;
    if ({cmd_a, en_a, sp_a, dout_a} !== '0) $display("[TB] FAIL reset_outputs: got %h expected 0", {cmd_a, en_a, sp_a, dout_a});
    else n_pass++;
    n_checks++;
    if (bad_a !== 16'h0) $display("[TB] FAIL reset_bad_frames: got %h expected 0000", bad_a);
    else n_pass++;
    n_checks++;
    if (tx_a !== {32'h61746164, 208'h0}) $display("[TB] FAIL reset_tx: got %h expected %h", tx_a, {32'h61746164, 208'h0});
    else n_pass++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_valid_frame();
    fb_a  = {128'h0, 32'h11223344};
    pv_a  = 32'hCAFEF00D;
    din_a = 8'hC3;
    send_a(frame_a(32'h74697277, 32'h00001000, 32'hFFFFFF00, 32'h0000ABCD, 8'h05, 8'h05));
    n_checks++;
    if (cmd_a !== {32'hFFFFFF00, 96'h0, 32'h00001000}) $display("[TB] FAIL valid_cmd: got %h expected %h", cmd_a, {32'hFFFFFF00, 96'h0, 32'h00001000});
    else n_pass++;
    n_checks++;
    if (en_a !== 5'b00101) $display("[TB] FAIL valid_enable: got %b expected 00101", en_a);
    else n_pass++;
    n_checks++;
    if (dout_a !== 8'h05) $display("[TB] FAIL valid_dout: got %h expected 05", dout_a);
    else n_pass++;
    n_checks++;
    if (sp_a !== 32'h0000ABCD) $display("[TB] FAIL valid_setpoint: got %h expected 0000abcd", sp_a);
    else n_pass++;
    n_checks++;
    if (err_a !== 1'b0) $display("[TB] FAIL valid_error: got %b expected 0", err_a);
    else n_pass++;
    n_checks++;
    if (tx_a[239:208] !== 32'h61746164) $display("[TB] FAIL valid_tx_header: got %h expected 61746164", tx_a[239:208]);
    else n_pass++;
    n_checks++;
    if (tx_a[207:176] !== 32'h44332211) $display("[TB] FAIL valid_tx_fb0: got %h expected 44332211", tx_a[207:176]);
    else n_pass++;
    n_checks++;
    if (tx_a[47:0] !== 48'h0DF0FECAC300) $display("[TB] FAIL valid_tx_pv_din: got %h expected 0df0fecac300", tx_a[47:0]);
    else n_pass++;
  endtask

  task automatic test_bad_header();
    send_a(frame_a(32'h00000000, 32'h00002222, 32'h0, 32'h0, 8'h1F, 8'hAA));
    n_checks++;
    if ({cmd_a, en_a, dout_a} !== {32'hFFFFFF00, 96'h0, 32'h00001000, 5'b00101, 8'h05})
      $display("[TB] FAIL bad_outputs_held: got %h expected %h", {cmd_a, en_a, dout_a}, {32'hFFFFFF00, 96'h0, 32'h00001000, 5'b00101, 8'h05});
    else n_pass++;
    n_checks++;
    if (bad_a !== 16'h0001) $display("[TB] FAIL bad_count_first: got %h expected 0001", bad_a);
    else n_pass++;
    n_checks++;
    if (err_a !== 1'b0) $display("[TB] FAIL bad_error: got %b expected 0", err_a);
    else n_pass++;
    frame_done_a = 1'b1;
    repeat (65540) @(posedge clk);
    #1 frame_done_a = 1'b0;
    n_checks++;
    if (bad_a !== 16'hFFFF) $display("[TB] FAIL bad_count_saturate: got %h expected ffff", bad_a);
    else n_pass++;
    n_checks++;
    if (err_a !== 1'b1) $display("[TB] FAIL bad_frames_timeout: got %b expected 1", err_a);
    else n_pass++;
  endtask

  task automatic test_timeout();
    send_a(frame_a(32'h74697277, 32'h00003000, 32'h0, 32'h0, 8'h1A, 8'h3C));
    n_checks++;
    if ({err_a, en_a, cmd_a[31:0]} !== {1'b0, 5'b11010, 32'h00003000}) $display("[TB] FAIL timeout_recover: got %h expected %h", {err_a, en_a, cmd_a[31:0]}, {1'b0, 5'b11010, 32'h00003000});
    else n_pass++;
    repeat (99) @(posedge clk);
    #1;
    n_checks++;
    if ({err_a, en_a} !== {1'b0, 5'b11010}) $display("[TB] FAIL timeout_early: got %h expected %h", {err_a, en_a}, {1'b0, 5'b11010});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (err_a !== 1'b1) $display("[TB] FAIL timeout_error: got %b expected 1", err_a);
    else n_pass++;
    n_checks++;
    if ({cmd_a, en_a, sp_a, dout_a} !== '0) $display("[TB] FAIL timeout_outputs: got %h expected 0", {cmd_a, en_a, sp_a, dout_a});
    else n_pass++;
    send_a(frame_a(32'h74697277, 32'h00004000, 32'h0, 32'h0, 8'h03, 8'h81));
    n_checks++;
    if ({err_a, en_a, dout_a, cmd_a[31:0]} !== {1'b0, 5'b00011, 8'h81, 32'h00004000}) $display("[TB] FAIL timeout_rerun: got %h expected %h", {err_a, en_a, dout_a, cmd_a[31:0]}, {1'b0, 5'b00011, 8'h81, 32'h00004000});
    else n_pass++;
  endtask

  task automatic test_estop();
    estop_a = 1'b1;
    send_a(frame_a(32'h74697277, 32'h00005000, 32'h0, 32'h0, 8'h1F, 8'hFF));
    n_checks++;
    if ({err_a, en_a, dout_a, cmd_a} !== {1'b1, 173'h0}) $display("[TB] FAIL estop_entry: got %h expected %h", {err_a, en_a, dout_a, cmd_a}, {1'b1, 173'h0});
    else n_pass++;
    n_checks++;
    if (tx_a[239:208] !== 32'h70747365) $display("[TB] FAIL estop_tx_header: got %h expected 70747365", tx_a[239:208]);
    else n_pass++;
    estop_a = 1'b0;
    send_a(frame_a(32'h74697277, 32'h00006000, 32'h0, 32'h0, 8'h1F, 8'hFF));
    n_checks++;
    if ({err_a, en_a, dout_a, cmd_a} !== {1'b1, 173'h0}) $display("[TB] FAIL estop_to_wait: got %h expected %h", {err_a, en_a, dout_a, cmd_a}, {1'b1, 173'h0});
    else n_pass++;
    n_checks++;
    if (tx_a[239:208] !== 32'h70747365) $display("[TB] FAIL estop_state_tx_header: got %h expected 70747365", tx_a[239:208]);
    else n_pass++;
    send_a(frame_a(32'h74697277, 32'h00007000, 32'h0, 32'h0, 8'h11, 8'h42));
    n_checks++;
    if ({err_a, en_a, dout_a, cmd_a[31:0]} !== {1'b0, 5'b10001, 8'h42, 32'h00007000}) $display("[TB] FAIL estop_rerun: got %h expected %h", {err_a, en_a, dout_a, cmd_a[31:0]}, {1'b0, 5'b10001, 8'h42, 32'h00007000});
    else n_pass++;
    n_checks++;
    if (tx_a[239:208] !== 32'h61746164) $display("[TB] FAIL estop_tx_data_header: got %h expected 61746164", tx_a[239:208]);
    else n_pass++;
  endtask

  task automatic test_wide_layout();
    fb_b  = {32'h11223344, 224'h0, 32'h01020304};
    pv_b  = {32'h0000BEEF, 32'hDEADBEEF};
    din_b = 16'hA55A;
    rx_b  = {32'h77726974, 256'h0, 32'h78563412, 32'h0, 16'h0100, 8'h5A, 24'h0};
    frame_done_b = 1'b1;
    @(posedge clk); #1;
    frame_done_b = 1'b0;
    n_checks++;
    if ({err_b, en_b, dout_b} !== {1'b0, 9'h100, 8'h5A}) $display("[TB] FAIL wide_enable_dout: got %h expected %h", {err_b, en_b, dout_b}, {1'b0, 9'h100, 8'h5A});
    else n_pass++;
    n_checks++;
    if (cmd_b !== {32'h12345678, 256'h0}) $display("[TB] FAIL wide_cmd8: got %h expected %h", cmd_b, {32'h12345678, 256'h0});
    else n_pass++;
    n_checks++;
    if ({tx_b[399:368], tx_b[367:336]} !== {32'h61746164, 32'h04030201}) $display("[TB] FAIL wide_tx_head_fb0: got %h expected 6174616404030201", {tx_b[399:368], tx_b[367:336]});
    else n_pass++;
    n_checks++;
    if (tx_b[111:80] !== 32'h44332211) $display("[TB] FAIL wide_tx_fb8: got %h expected 44332211", tx_b[111:80]);
    else n_pass++;
    n_checks++;
    if (tx_b[79:0] !== 80'hEFBEADDEEFBE0000A55A) $display("[TB] FAIL wide_tx_pv_din: got %h expected efbeaddeefbe0000a55a", tx_b[79:0]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({err_a, err_b} !== 2'b11) $display("[TB] FAIL areset_error: got %b expected 11", {err_a, err_b});
    else n_pass++;
    n_checks++;
    if ({cmd_a, en_a, sp_a, dout_a, bad_a} !== '0) $display("[TB] FAIL areset_outputs: got %h expected 0", {cmd_a, en_a, sp_a, dout_a, bad_a});
    else n_pass++;
    n_checks++;
    if (tx_a !== {32'h61746164, 208'h0}) $display("[TB] FAIL areset_tx: got %h expected %h", tx_a, {32'h61746164, 208'h0});
    else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    frame_done_a = 1'b0; estop_a = 1'b0; rx_a = '0; fb_a = '0; pv_a = '0; din_a = '0;
    frame_done_b = 1'b0; estop_b = 1'b0; rx_b = '0; fb_b = '0; pv_b = '0; din_b = '0;
    test_reset();
    test_valid_frame();
    test_bad_header();
    test_timeout();
    test_estop();
    test_wide_layout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
